// File: rtl/board_sprite_fetch.sv
// Raster-to-sprite address generator for an 8x8 board: tracks the pixel position with
// counters, reads the piece code of the current square, and forms the sprite ROM address.
module board_sprite_fetch #(
  parameter int SQUARE_DIM = 60,
  parameter int BOARD_X0   = 80,
  parameter int BOARD_Y0   = 0,
  parameter int COORD_W    = 10,
  parameter int ADDR_W     = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid,
  input  logic              sol,
  input  logic              sof,
  input  logic              flip,
  output logic [5:0]        sq_idx,
  input  logic [3:0]        sq_code,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              out_valid,
  output logic              sprite_hit,
  output logic              in_board,
  output logic              square_light
);

  localparam int PX_W    = (SQUARE_DIM > 1) ? $clog2(SQUARE_DIM) : 1;
  localparam int SQ_AREA = SQUARE_DIM * SQUARE_DIM;
  localparam logic [COORD_W-1:0] BOARD_SPAN = COORD_W'(8 * SQUARE_DIM);
  localparam logic [PX_W-1:0]    PX_LAST    = PX_W'(SQUARE_DIM - 1);

  // Position of the most recently accepted pixel
  logic [COORD_W-1:0] x_q, y_q;
  logic [PX_W-1:0]    px_q, py_q;
  logic [2:0]         col_q, row_q;
  logic               flip_q, seen_q;

  // Position of the pixel offered this cycle
  logic [COORD_W-1:0] x_cur, y_cur, dx, dy;
  logic [PX_W-1:0]    px_cur, py_cur;
  logic [2:0]         col_cur, row_cur;
  logic               flip_eff, in_cur;
  logic [5:0]         rc_cur;

  always_comb begin
    x_cur = sol ? '0 : x_q + 1'b1;
    y_cur = y_q;
    if (sol) y_cur = sof ? '0 : y_q + 1'b1;
    // Offsets from the board origin; wrap-around makes left/above-board values huge
    dx = x_cur - COORD_W'(BOARD_X0);
    dy = y_cur - COORD_W'(BOARD_Y0);

    px_cur  = px_q + 1'b1;
    col_cur = col_q;
    if (dx == '0) begin
      px_cur  = '0;
      col_cur = '0;
    end else if (px_q == PX_LAST) begin
      px_cur  = '0;
      col_cur = col_q + 1'b1;
    end

    py_cur  = py_q;
    row_cur = row_q;
    if (sol) begin
      if (dy == '0) begin
        py_cur  = '0;
        row_cur = '0;
      end else if (py_q == PX_LAST) begin
        py_cur  = '0;
        row_cur = row_q + 1'b1;
      end else begin
        py_cur = py_q + 1'b1;
      end
    end

    flip_eff = sof ? flip : flip_q;
    in_cur   = (seen_q || sof) && (dx < BOARD_SPAN) && (dy < BOARD_SPAN);
    rc_cur   = {row_cur, col_cur};
  end

  // Flipped view is a point reflection of the board: 63 - idx is the bitwise inverse
  assign sq_idx = Reset_n ? (flip_eff ? ~rc_cur : rc_cur) : 6'd0;

  // Stage 1: position counters and the per-pixel data that waits for sq_code
  logic            v1, ib1, light1;
  logic [PX_W-1:0] px1, py1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      flip_q <= 1'b0;
      seen_q <= 1'b0;
      v1     <= 1'b0;
      ib1    <= 1'b0;
      light1 <= 1'b0;
      px1    <= '0;
      py1    <= '0;
    end else begin
      v1 <= pix_valid;
      if (pix_valid) begin
        x_q    <= x_cur;
        y_q    <= y_cur;
        px_q   <= px_cur;
        py_q   <= py_cur;
        col_q  <= col_cur;
        row_q  <= row_cur;
        if (sof) begin
          flip_q <= flip;
          seen_q <= 1'b1;
        end
        ib1    <= in_cur;
        light1 <= ~(row_cur[0] ^ col_cur[0]);
        px1    <= px_cur;
        py1    <= py_cur;
      end
    end
  end

  // Stage 2: decode the returned piece code into a sprite address
  logic [2:0]        ptype;
  logic              hit2;
  logic [3:0]        sprite_idx;
  logic [ADDR_W-1:0] addr2;

  always_comb begin
    ptype      = sq_code[2:0];
    hit2       = ib1 && (ptype != 3'd0) && (ptype != 3'd7);
    sprite_idx = {ptype - 3'd1, ~sq_code[3]};
    addr2      = ADDR_W'(sprite_idx) * ADDR_W'(SQ_AREA)
               + ADDR_W'(py1) * ADDR_W'(SQUARE_DIM)
               + ADDR_W'(px1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid    <= 1'b0;
      in_board     <= 1'b0;
      sprite_hit   <= 1'b0;
      square_light <= 1'b0;
      rom_addr     <= '0;
    end else begin
      out_valid    <= v1;
      in_board     <= v1 && ib1;
      sprite_hit   <= v1 && hit2;
      square_light <= v1 && light1;
      rom_addr     <= (v1 && hit2) ? addr2 : '0;
    end
  end

endmodule

// File: tb/tb_board_sprite_fetch.sv
// Randomized raster stimulus against a division-based reference model of the board
// geometry, with a behavioural one-cycle-latency board RAM.
module tb_board_sprite_fetch;
  localparam int SQ = 60;
  localparam int X0 = 80;
  localparam int Y0 = 0;
  localparam int AW = 17;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          sol = 1'b0;
  logic          sof = 1'b0;
  logic          flip = 1'b0;
  logic [5:0]    sq_idx;
  logic [3:0]    sq_code;
  logic [AW-1:0] rom_addr;
  logic          out_valid, sprite_hit, in_board, square_light;

  board_sprite_fetch #(
    .SQUARE_DIM(SQ), .BOARD_X0(X0), .BOARD_Y0(Y0), .COORD_W(10), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .sol(sol), .sof(sof),
    .flip(flip), .sq_idx(sq_idx), .sq_code(sq_code), .rom_addr(rom_addr),
    .out_valid(out_valid), .sprite_hit(sprite_hit), .in_board(in_board),
    .square_light(square_light)
  );

  always #5 Clk = ~Clk;

  logic [3:0] board [64];
  always @(posedge Clk) sq_code <= board[sq_idx];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit v;
    bit ib;
    bit hit;
    bit light;
    int addr;
    int idx;
  } exp_t;

  // Position of the pixel currently driven, as the raster generator knows it
  int m_x = 0;
  int m_y = 0;
  bit m_seen = 0;
  bit m_flip = 0;

  function automatic exp_t idle_exp();
    exp_t e;
    e.v = 0; e.ib = 0; e.hit = 0; e.light = 0; e.addr = 0; e.idx = 0;
    return e;
  endfunction

  function automatic exp_t model(int x, int y, bit seen, bit fl);
    exp_t e;
    int row, col, px, py, code, typ, spr;
    e = idle_exp();
    e.v  = 1;
    e.ib = seen && x >= X0 && x < X0 + 8*SQ && y >= Y0 && y < Y0 + 8*SQ;
    if (e.ib) begin
      col = (x - X0) / SQ;
      px  = (x - X0) % SQ;
      row = (y - Y0) / SQ;
      py  = (y - Y0) % SQ;
      e.idx   = fl ? 63 - (row*8 + col) : row*8 + col;
      code    = int'(board[e.idx]);
      typ     = code % 8;
      e.light = ((row + col) % 2) == 0;
      e.hit   = (typ >= 1) && (typ <= 6);
      spr     = 2*(typ - 1) + ((code >= 8) ? 0 : 1);
      if (e.hit) e.addr = spr*SQ*SQ + py*SQ + px;
    end
    return e;
  endfunction

  exp_t h1, h2, cur_e;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_board", in_board, 0);
      check_eq("rst_sprite_hit", sprite_hit, 0);
      check_eq("rst_rom_addr", rom_addr, 0);
      check_eq("rst_sq_idx", sq_idx, 0);
      h1 = idle_exp();
      h2 = idle_exp();
    end else begin
      check_eq("out_valid", out_valid, h2.v);
      if (h2.v) begin
        check_eq("in_board", in_board, h2.ib);
        check_eq("sprite_hit", sprite_hit, h2.hit);
        check_eq("rom_addr", rom_addr, h2.addr);
        if (h2.ib) check_eq("square_light", square_light, h2.light);
      end
      h2 = h1;
      if (pix_valid) begin
        cur_e = model(m_x, m_y, m_seen, m_flip);
        if (cur_e.ib) check_eq("sq_idx", sq_idx, cur_e.idx);
        h1 = cur_e;
      end else begin
        h1 = idle_exp();
      end
    end
  end

  task automatic step_idle();
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    sol  = 1'($urandom);
    sof  = 1'($urandom);
    flip = 1'($urandom);
  endtask

  task automatic step_pix(input bit l, input bit f, input bit fl);
    if ($urandom_range(0, 5) == 0) step_idle();
    @(posedge Clk); #1;
    pix_valid = 1'b1;
    sol  = l;
    sof  = f;
    flip = f ? fl : 1'($urandom);
    if (l) begin
      m_x = 0;
      m_y = f ? 0 : m_y + 1;
    end else begin
      m_x++;
    end
    if (f) begin
      m_seen = 1;
      m_flip = fl;
    end
  endtask

  task automatic run_line(input bit first, input bit fl, input int len);
    step_pix(1'b1, first, fl);
    for (int i = 1; i < len; i++) step_pix(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int line_len(int ln);
    if (ln == 0 || ln == 61 || ln % 15 == 7) return 600;
    return int'($urandom_range(60, 250));
  endfunction

  task automatic fill_board();
    for (int i = 0; i < 64; i++) board[i] = 4'($urandom);
    board[0] = 4'b1100;
    board[1] = 4'b1001;
    board[2] = 4'b0111;
    board[8] = 4'b0110;
    board[9] = 4'b0000;
  endtask

  task automatic pulse_reset();
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    sol = 1'b0;
    sof = 1'b0;
    #2 Reset_n = 1'b0;
    m_seen = 0;
    #1;
    check_eq("async_out_valid", out_valid, 0);
    check_eq("async_rom_addr", rom_addr, 0);
    check_eq("async_sprite_hit", sprite_hit, 0);
    check_eq("async_in_board", in_board, 0);
    check_eq("async_square_light", square_light, 0);
    check_eq("async_sq_idx", sq_idx, 0);
    @(posedge Clk);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_board();
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_rom_addr", rom_addr, 0);
    check_eq("reset_square_light", square_light, 0);
    Reset_n = 1'b1;

    // Pixels before any sof must never report board coverage
    run_line(1'b0, 1'b0, 120);
    run_line(1'b0, 1'b0, 120);

    // Frame A: white perspective, long lines at y=0 and y=61
    for (int ln = 0; ln < 70; ln++) run_line(ln == 0, 1'b0, line_len(ln));
    repeat (4) step_idle();
    fill_board();

    // Frame B: black perspective, reset pulsed mid-line, rest of frame without sof
    for (int ln = 0; ln < 25; ln++) begin
      if (ln == 20) begin
        step_pix(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 150; i++) step_pix(1'b0, 1'b0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 150; i++) step_pix(1'b0, 1'b0, 1'b0);
      end else begin
        run_line(ln == 0, 1'b1, line_len(ln));
      end
    end
    repeat (4) step_idle();
    fill_board();

    // Frame C: black perspective after reset; Frame D: back to white
    for (int ln = 0; ln < 30; ln++) run_line(ln == 0, 1'b1, line_len(ln));
    for (int ln = 0; ln < 20; ln++) run_line(ln == 0, 1'b0, line_len(ln));
    repeat (4) step_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/board_sprite_fetch.md
BOARD_SPRITE_FETCH -- requirements
Module: board_sprite_fetch

Interface
REQ-001 SHALL have parameter SQUARE_DIM, default 60: square and sprite edge length, in pixels.
REQ-002 SHALL have parameter BOARD_X0, default 80: leftmost board pixel column.
REQ-003 SHALL have parameter BOARD_Y0, default 0: topmost board pixel row.
REQ-004 SHALL have parameter COORD_W, default 10: width of the pixel counters.
REQ-005 SHALL have parameter ADDR_W, default 17: ROM address width; must be at least clog2(12*SQUARE_DIM*SQUARE_DIM).
REQ-006 SHALL have port Clk, input, 1 bit: the only clock; everything is rising-edge.
REQ-007 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pix_valid, input, 1 bit: one raster pixel this cycle.
REQ-009 SHALL have port sol, input, 1 bit: start of line; qualified by pix_valid; marks pixel x=0.
REQ-010 SHALL have port sof, input, 1 bit: start of frame; qualified by pix_valid; always coincident with sol; marks pixel (0,0).
REQ-011 SHALL have port flip, input, 1 bit: board orientation request (1 = black perspective).
REQ-012 SHALL have port sq_idx, output, 6 bits: board RAM read address; {row,col} in flipped space.
REQ-013 SHALL have port sq_code, input, 4 bits: board RAM read data; valid exactly 1 cycle after sq_idx is issued.
REQ-014 SHALL have port rom_addr, output, ADDR_W bits: sprite ROM address.
REQ-015 SHALL have port out_valid, output, 1 bit: rom_addr, sprite_hit, in_board and square_light are valid this cycle.
REQ-016 SHALL have port sprite_hit, output, 1 bit: the pixel lies on a square holding a piece.
REQ-017 SHALL have port in_board, output, 1 bit: the pixel lies inside the 8x8 board area.
REQ-018 SHALL have port square_light, output, 1 bit: 1 when (row+col) is even, i.e. a light square.

Function
REQ-019 SHALL track pixel position with counters only; no dividers or multipliers by non-constants.
REQ-020 SHALL update x on each pix_valid: 0 if sol is high, otherwise x+1.
REQ-021 SHALL update y on each pix_valid with sol: 0 if sof is high, otherwise y+1.
REQ-022 SHALL maintain px/col: px=0, col=0 at x==BOARD_X0; px wraps at SQUARE_DIM-1 to 0 with col+1 while in board.
REQ-023 SHALL maintain py/row identically to px/col on the y axis.
REQ-024 SHALL assert in_board iff BOARD_X0<=x<BOARD_X0+8*SQUARE_DIM and BOARD_Y0<=y<BOARD_Y0+8*SQUARE_DIM.
REQ-025 SHALL latch flip at each sof pixel into flip_q; flip changes mid-frame are ignored until the next sof.
REQ-026 SHALL drive sq_idx = {row,col} when flip_q=0 and 63-{row,col} when flip_q=1; in-square px/py are never mirrored.
REQ-027 SHALL use a 2-stage pipeline: stage 1 issues sq_idx on the cycle the pixel is accepted; stage 2 combines the returned sq_code with the delayed px/py.
REQ-028 SHALL assert out_valid exactly 2 cycles after the accepting pix_valid, one result per accepted pixel, with no stalls and no backpressure.
REQ-029 SHALL decode the piece as type=sq_code[2:0] and black=sq_code[3]; a piece is present iff 1<=type<=6.
REQ-030 SHALL compute sprite index = 2*(type-1)+(black?0:1), giving pawn_b=0, pawn_w=1, … king_w=11.
REQ-031 SHALL compute rom_addr = index*SQUARE_DIM*SQUARE_DIM + py*SQUARE_DIM + px, with constant-folded products and no truncation within ADDR_W.
REQ-032 SHALL output sprite_hit=0 and rom_addr=0 when the pixel is outside the board or the square is empty or type is 0 or 7.
REQ-033 SHALL treat gaps in pix_valid as holds: counters keep their values and out_valid deasserts 2 cycles later.

Reset
REQ-034 SHALL, on Reset_n low, immediately clear every counter, flip_q, and all pipeline valids; out_valid, sprite_hit, in_board, square_light, rom_addr and sq_idx all read 0.
REQ-035 SHALL, after reset release mid-frame, keep in_board and sprite_hit low until the first sof is accepted.
REQ-036 SHALL produce no out_valid for pixels that were in flight when reset asserted.

Verification
REQ-037 SHALL be verified with: sof pixel, then pixels to (80,0); sq_code 4'b1100 -> sq_idx 0, out_valid 2 cycles later, rom_addr 21600, hit=1, light=1.
REQ-038 SHALL be verified with: same line at (139,0) -> rom_addr 21659; at (140,0) -> sq_idx 1, light=0, px=0.
REQ-039 SHALL be verified with: line y=61 at x=80 with sq_code 4'b0110 -> sq_idx 8, rom_addr 39600+60=39660, light=0.
REQ-040 SHALL be verified with: flip=1 at sof, pixel (80,0) -> sq_idx 63; flip toggled mid-frame -> sq_idx unchanged until the next sof.
REQ-041 SHALL be verified with: pixels (79,0) and (560,0), and code 4'b0111 on a board square -> hit=0, rom_addr=0; in_board 0,0,1 respectively.
REQ-042 SHALL be verified with: Reset_n pulsed low mid-line with 2 pixels in flight -> outputs 0 asynchronously, no stale out_valid, and no hit before the next sof.
